multi_bank_cmd_scheduler: RTL and testbench

Parametrised successor to the single-bank command scheduler. It arbitrates among NUM_BANKS bank FSMs and issues at most one DRAM command per cycle into the issue FIFO. It adds class priority, read/write direction grouping, an ACT rolling-window limiter, round-robin fairness and an optional age-promotion path. It sits between the bank controllers and the issue FIFO.

---
 rtl/multi_bank_cmd_scheduler.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multi_bank_cmd_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bank_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : multi_bank_cmd_scheduler
// Desc     : Arbitrates NUM_BANKS bank FSMs into one DRAM command per cycle.
//            Optional macro SCH_AGE_PROMOTE_EN adds age-based promotion.
// Revision : 1.0
// ============================================================================
module multi_bank_cmd_scheduler #(
    parameter int NUM_BANKS    = 8,
    parameter int ADDR_BITS    = 14,
    parameter int BA_BITS      = 3,
    parameter int STATE_W      = 4,
    parameter int RW_BURST_MAX = 4,
    parameter int ACT_WINDOW   = 16,
    parameter int ACT_MAX      = 4,
    parameter int AGE_LIMIT    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             isu_fifo_full,
    input  logic [NUM_BANKS*STATE_W-1:0]     ba_state,
    input  logic [NUM_BANKS*ADDR_BITS-1:0]   ba_addr,
    output logic [NUM_BANKS-1:0]             ba_stall,
    output logic [NUM_BANKS-1:0]             ba_grant,
    output logic [3+ADDR_BITS+BA_BITS-1:0]   sch_out,
    output logic                             sch_issue
);

    localparam logic [STATE_W-1:0] c_B_REFRESH_CHECK = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_B_PRE           = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_B_ACTIVE        = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_B_READ          = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_B_READA         = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_B_WRITE         = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_B_WRITEA        = STATE_W'(7);

    localparam logic [2:0] c_ATCMD_NOP       = 3'd0;
    localparam logic [2:0] c_ATCMD_ACTIVE    = 3'd1;
    localparam logic [2:0] c_ATCMD_READ      = 3'd2;
    localparam logic [2:0] c_ATCMD_RDA       = 3'd3;
    localparam logic [2:0] c_ATCMD_WRITE     = 3'd4;
    localparam logic [2:0] c_ATCMD_WRA       = 3'd5;
    localparam logic [2:0] c_ATCMD_PRECHARGE = 3'd6;
    localparam logic [2:0] c_ATCMD_REFRESH   = 3'd7;

    localparam int                 c_BURST_W   = $clog2(RW_BURST_MAX + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(RW_BURST_MAX);
    localparam logic [BA_BITS-1:0] c_LAST_BANK = BA_BITS'(NUM_BANKS - 1);
    localparam int                 c_OUT_W     = 3 + ADDR_BITS + BA_BITS;

    typedef enum logic [0:0] {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

    dir_t                    dir_q, dir_d;
    logic [c_BURST_W-1:0]    burst_q, burst_d;
    logic [BA_BITS-1:0]      rr_q, rr_d;
    logic [ACT_WINDOW-1:0]   act_win_q, act_win_d;
    logic [c_OUT_W-1:0]      sch_out_q, sch_out_d;
    logic                    sch_issue_q, sch_issue_d;

    logic [NUM_BANKS-1:0]    w_ref, w_pre, w_rd, w_wr, w_act, w_act_ok;
    logic [NUM_BANKS-1:0]    w_cur, w_opp;
    logic                    w_act_blocked, w_turn;
    logic [BA_BITS:0]        w_pk_ref, w_pk_pre, w_pk_cur, w_pk_opp, w_pk_act;
    logic                    w_found;
    logic [BA_BITS-1:0]      w_sel;
    logic [STATE_W-1:0]      w_sel_st;
    logic                    w_sel_rd, w_sel_wr, w_sel_act;
    logic [NUM_BANKS-1:0]    w_grant;

    // {found, index}: first set bit of vec scanning upward from ptr with wrap.
    function automatic logic [BA_BITS:0] rr_pick(input logic [NUM_BANKS-1:0] vec,
                                                 input logic [BA_BITS-1:0]   ptr);
        logic               found;
        logic [BA_BITS-1:0] sel;
        int                 idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
            if (!found && vec[idx]) begin
                found = 1'b1;
                sel   = idx[BA_BITS-1:0];
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [2:0] cmd_of(input logic [STATE_W-1:0] st);
        logic [2:0] cmd;
        cmd = c_ATCMD_NOP;
        case (st)
            c_B_REFRESH_CHECK: cmd = c_ATCMD_REFRESH;
            c_B_PRE:           cmd = c_ATCMD_PRECHARGE;
            c_B_ACTIVE:        cmd = c_ATCMD_ACTIVE;
            c_B_READ:          cmd = c_ATCMD_READ;
            c_B_READA:         cmd = c_ATCMD_RDA;
            c_B_WRITE:         cmd = c_ATCMD_WRITE;
            c_B_WRITEA:        cmd = c_ATCMD_WRA;
            default:           cmd = c_ATCMD_NOP;
        endcase
        return cmd;
    endfunction

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_decode
        logic [STATE_W-1:0] w_st;
        assign w_st      = ba_state[gi*STATE_W +: STATE_W];
        assign w_ref[gi] = (w_st == c_B_REFRESH_CHECK);
        assign w_pre[gi] = (w_st == c_B_PRE);
        assign w_act[gi] = (w_st == c_B_ACTIVE);
        assign w_rd[gi]  = (w_st == c_B_READ)  || (w_st == c_B_READA);
        assign w_wr[gi]  = (w_st == c_B_WRITE) || (w_st == c_B_WRITEA);
    end

    // The oldest slot leaves the window this cycle, so it no longer counts.
    assign w_act_blocked = ($countones(act_win_q) - int'(act_win_q[ACT_WINDOW-1])) >= ACT_MAX;
    assign w_act_ok      = w_act & {NUM_BANKS{~w_act_blocked}};
    assign w_cur         = (dir_q == DIR_WRITE) ? w_wr : w_rd;
    assign w_opp         = (dir_q == DIR_WRITE) ? w_rd : w_wr;
    assign w_turn        = (burst_q == c_BURST_MAX) && (|w_opp);

    assign w_pk_ref = rr_pick(w_ref,    rr_q);
    assign w_pk_pre = rr_pick(w_pre,    rr_q);
    assign w_pk_cur = rr_pick(w_cur,    rr_q);
    assign w_pk_opp = rr_pick(w_opp,    rr_q);
    assign w_pk_act = rr_pick(w_act_ok, rr_q);

`ifdef SCH_AGE_PROMOTE_EN
    logic [7:0]           age_q [NUM_BANKS];
    logic [7:0]           age_d [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_req_any, w_elig;
    logic                 w_age_found;
    logic [BA_BITS-1:0]   w_age_sel;
    logic [7:0]           w_age_best;

    assign w_req_any = w_ref | w_pre | w_rd | w_wr | w_act;
    assign w_elig    = w_ref | w_pre | w_rd | w_wr | w_act_ok;

    always_comb begin
        w_age_found = 1'b0;
        w_age_sel   = '0;
        w_age_best  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (w_elig[i] && (int'(age_q[i]) >= AGE_LIMIT) &&
                (!w_age_found || (age_q[i] > w_age_best))) begin
                w_age_found = 1'b1;
                w_age_sel   = BA_BITS'(i);
                w_age_best  = age_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            age_d[i] = age_q[i];
            if (!w_req_any[i] || w_grant[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != 8'hFF) begin
                age_d[i] = age_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) age_q[i] <= age_d[i];
        end
    end
`endif

    // Class ladder; a pending direction turn lifts the opposite column class.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        if (rst_n && !isu_fifo_full) begin
`ifdef SCH_AGE_PROMOTE_EN
            if (w_age_found) begin
                w_found = 1'b1;
                w_sel   = w_age_sel;
            end else
`endif
            if (w_pk_ref[BA_BITS]) begin
                w_found = 1'b1;
                w_sel   = w_pk_ref[BA_BITS-1:0];
            end else if (w_pk_pre[BA_BITS]) begin
                w_found = 1'b1;
                w_sel   = w_pk_pre[BA_BITS-1:0];
            end else if (w_turn) begin
                w_found = 1'b1;
                w_sel   = w_pk_opp[BA_BITS-1:0];
            end else if (w_pk_cur[BA_BITS]) begin
                w_found = 1'b1;
                w_sel   = w_pk_cur[BA_BITS-1:0];
            end else if (w_pk_act[BA_BITS]) begin
                w_found = 1'b1;
                w_sel   = w_pk_act[BA_BITS-1:0];
            end else if (w_pk_opp[BA_BITS]) begin
                w_found = 1'b1;
                w_sel   = w_pk_opp[BA_BITS-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) w_grant[w_sel] = 1'b1;
    end

    assign w_sel_st  = ba_state[int'(w_sel)*STATE_W +: STATE_W];
    assign w_sel_rd  = (w_sel_st == c_B_READ)  || (w_sel_st == c_B_READA);
    assign w_sel_wr  = (w_sel_st == c_B_WRITE) || (w_sel_st == c_B_WRITEA);
    assign w_sel_act = (w_sel_st == c_B_ACTIVE);

    always_comb begin
        dir_d       = dir_q;
        burst_d     = burst_q;
        rr_d        = rr_q;
        act_win_d   = {act_win_q[ACT_WINDOW-2:0], w_found && w_sel_act};
        sch_out_d   = sch_out_q;
        sch_issue_d = w_found;
        if (w_found) begin
            rr_d      = (w_sel == c_LAST_BANK) ? '0 : w_sel + 1'b1;
            sch_out_d = {cmd_of(w_sel_st), ba_addr[int'(w_sel)*ADDR_BITS +: ADDR_BITS], w_sel};
            if (w_sel_rd || w_sel_wr) begin
                if ((dir_q == DIR_READ) == w_sel_rd) begin
                    if (burst_q != c_BURST_MAX) burst_d = burst_q + 1'b1;
                end else begin
                    dir_d   = w_sel_rd ? DIR_READ : DIR_WRITE;
                    burst_d = c_BURST_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= DIR_WRITE;
            burst_q     <= '0;
            rr_q        <= '0;
            act_win_q   <= '0;
            sch_out_q   <= '0;
            sch_issue_q <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            burst_q     <= burst_d;
            rr_q        <= rr_d;
            act_win_q   <= act_win_d;
            sch_out_q   <= sch_out_d;
            sch_issue_q <= sch_issue_d;
        end
    end

    assign ba_grant  = w_grant;
    assign ba_stall  = ~w_grant;
    assign sch_out   = sch_out_q;
    assign sch_issue = sch_issue_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_bank_cmd_scheduler
// Desc     : Directed bench with a cycle-level reference model of the scheduler.
// Revision : 1.0
// ============================================================================
module tb_multi_bank_cmd_scheduler;

    localparam int NB = 8, AW = 14, BW = 3, SW = 4;
    localparam int RWMAX = 4, AWIN = 16, AMAX = 4;
    localparam int OW = 3 + AW + BW;

    localparam logic [3:0] S_IDLE = 4'd0, S_REF = 4'd1, S_PRE = 4'd2, S_ACT = 4'd3;
    localparam logic [3:0] S_RD = 4'd4, S_RDA = 4'd5, S_WR = 4'd6, S_WRA = 4'd7;
    localparam logic [2:0] K_NOP = 3'd0, K_ACT = 3'd1, K_RD = 3'd2, K_RDA = 3'd3;
    localparam logic [2:0] K_WR = 3'd4, K_WRA = 3'd5, K_PRE = 3'd6, K_REF = 3'd7;
    localparam int C_NONE = -1, C_REF = 0, C_PRE = 1, C_RD = 2, C_WR = 3, C_ACT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              full;
    logic [NB*SW-1:0]  st;
    logic [NB*AW-1:0]  ad;
    logic [NB-1:0]     ba_stall, ba_grant;
    logic [OW-1:0]     sch_out;
    logic              sch_issue;

    multi_bank_cmd_scheduler #(
        .NUM_BANKS(NB), .ADDR_BITS(AW), .BA_BITS(BW), .STATE_W(SW),
        .RW_BURST_MAX(RWMAX), .ACT_WINDOW(AWIN), .ACT_MAX(AMAX), .AGE_LIMIT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .isu_fifo_full(full),
        .ba_state(st), .ba_addr(ad),
        .ba_stall(ba_stall), .ba_grant(ba_grant),
        .sch_out(sch_out), .sch_issue(sch_issue)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(160 + i * 1031);
    endfunction

    function automatic int cls_of(input logic [3:0] s);
        case (s)
            S_REF:        return C_REF;
            S_PRE:        return C_PRE;
            S_RD, S_RDA:  return C_RD;
            S_WR, S_WRA:  return C_WR;
            S_ACT:        return C_ACT;
            default:      return C_NONE;
        endcase
    endfunction

    function automatic logic [2:0] cmd_of(input logic [3:0] s);
        case (s)
            S_REF: return K_REF;
            S_PRE: return K_PRE;
            S_RD:  return K_RD;
            S_RDA: return K_RDA;
            S_WR:  return K_WR;
            S_WRA: return K_WRA;
            S_ACT: return K_ACT;
            default: return K_NOP;
        endcase
    endfunction

    // Reference model: score = priority level * 32 + round-robin distance.
    bit            m_dir_rd;
    int            m_burst, m_rr, cyc;
    int            act_t[$];
    logic          m_issue;
    logic [OW-1:0] m_out;
    int            best, best_score, lvl, sc, nact, c;
    bit            blocked, opp_pend, turn;
    logic [NB-1:0] eg, es;

    initial begin
        m_dir_rd = 0; m_burst = 0; m_rr = 0; cyc = 0; m_issue = 0; m_out = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_dir_rd = 0; m_burst = 0; m_rr = 0; m_issue = 0; m_out = '0;
            act_t.delete();
            chk("rst_grant", ba_grant, 0);
            chk("rst_stall", ba_stall, 32'hFF);
            chk("rst_issue", sch_issue, 0);
            chk("rst_out", sch_out, 0);
        end else begin
            nact = 0;
            foreach (act_t[k]) if (cyc - act_t[k] < AWIN) nact++;
            blocked  = (nact >= AMAX);
            opp_pend = 0;
            for (int i = 0; i < NB; i++) begin
                c = cls_of(st[i*SW +: SW]);
                if ((c == C_RD && !m_dir_rd) || (c == C_WR && m_dir_rd)) opp_pend = 1;
            end
            turn = (m_burst == RWMAX) && opp_pend;
            best = -1;
            best_score = 1 << 30;
            if (!full) begin
                for (int i = 0; i < NB; i++) begin
                    c = cls_of(st[i*SW +: SW]);
                    if (c == C_NONE || (c == C_ACT && blocked)) continue;
                    case (c)
                        C_REF:   lvl = 0;
                        C_PRE:   lvl = 2;
                        C_ACT:   lvl = 6;
                        default: lvl = ((c == C_RD) == m_dir_rd) ? 4 : (turn ? 3 : 8);
                    endcase
                    sc = lvl * 32 + (i - m_rr + NB) % NB;
                    if (sc < best_score) begin
                        best_score = sc;
                        best = i;
                    end
                end
            end
            eg = '0;
            if (best >= 0) eg[best] = 1'b1;
            es = ~eg;
            chk("grant", ba_grant, eg);
            chk("stall", ba_stall, es);
            chk("issue", sch_issue, m_issue);
            chk("out", sch_out, m_out);
            m_issue = (best >= 0);
            if (best >= 0) begin
                m_out = {cmd_of(st[best*SW +: SW]), ad[best*AW +: AW], BW'(best)};
                m_rr  = (best + 1) % NB;
                c = cls_of(st[best*SW +: SW]);
                if (c == C_ACT) act_t.push_back(cyc);
                if (c == C_RD || c == C_WR) begin
                    if ((c == C_RD) == m_dir_rd) begin
                        if (m_burst < RWMAX) m_burst++;
                    end else begin
                        m_dir_rd = (c == C_RD);
                        m_burst  = 1;
                    end
                end
            end
            while (act_t.size() > 0 && cyc - act_t[0] >= AWIN) void'(act_t.pop_front());
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bank(input int i, input logic [3:0] s);
        st[i*SW +: SW] = s;
    endtask

    task automatic all_idle();
        for (int i = 0; i < NB; i++) set_bank(i, S_IDLE);
    endtask

    logic [7:0] g [20];
    logic [7:0] exp_dir [9];
    int         nz;

    initial begin
        rst_n = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            set_bank(i, S_ACT);
            ad[i*AW +: AW] = addr_of(i);
        end
        #1 rst_n = 1'b0;

        // Reset held with every bank requesting.
        repeat (3) begin
            @(negedge clk);
            chk("lit_rst_issue", sch_issue, 0);
            chk("lit_rst_stall", ba_stall, 32'hFF);
            chk("lit_rst_cmd", sch_out[OW-1 -: 3], K_NOP);
        end
        tick();
        rst_n = 1'b1;
        set_bank(6, S_IDLE);
        set_bank(7, S_IDLE);

        // ACT window: six banks requesting ACT continuously.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            g[k] = ba_grant;
            if (k == 10) chk("lit_act_blocked_stall", ba_stall, 32'hFF);
            tick();
        end
        all_idle();
        chk("lit_first_grant_bank0", g[0], 8'h01);
        chk("lit_act_4th", g[3], 8'h08);
        chk("lit_act_5th_blocked", g[4], 8'h00);
        chk("lit_act_15_blocked", g[15], 8'h00);
        nz = 0;
        for (int k = 0; k < 16; k++) if (g[k] != 0) nz++;
        chk("lit_act_count_window", nz, 4);
        chk("lit_act_5th_at_16", g[16], 8'h10);
        chk("lit_act_6th", g[17], 8'h20);
        chk("lit_act_wrap", g[18], 8'h01);
        repeat (20) tick();

        // Class priority: REF over PRE over ACT.
        set_bank(2, S_ACT);
        set_bank(5, S_PRE);
        set_bank(6, S_REF);
        @(negedge clk);
        chk("lit_prio_ref", ba_grant, 8'h40);
        tick();
        set_bank(6, S_IDLE);
        @(negedge clk);
        chk("lit_prio_pre", ba_grant, 8'h20);
        chk("lit_prio_ref_out", sch_out, {K_REF, addr_of(6), 3'd6});
        chk("lit_prio_ref_issue", sch_issue, 1);
        tick();
        set_bank(5, S_IDLE);
        @(negedge clk);
        chk("lit_prio_act", ba_grant, 8'h04);
        chk("lit_prio_pre_out", sch_out, {K_PRE, addr_of(5), 3'd5});
        tick();
        set_bank(2, S_IDLE);
        @(negedge clk);
        chk("lit_prio_none", ba_grant, 8'h00);
        chk("lit_prio_act_out", sch_out, {K_ACT, addr_of(2), 3'd2});
        tick();
        @(negedge clk);
        chk("lit_idle_issue", sch_issue, 0);
        chk("lit_idle_out_hold", sch_out, {K_ACT, addr_of(2), 3'd2});
        tick();

        // Direction grouping: four writes, turn to read, four reads, turn back.
        for (int i = 0; i < 4; i++) set_bank(i, S_WR);
        set_bank(4, S_RD);
        exp_dir = '{8'h08, 8'h01, 8'h02, 8'h04, 8'h10, 8'h10, 8'h10, 8'h10, 8'h01};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            g[k] = ba_grant;
            if (k == 5) chk("lit_dir_read_out", sch_out, {K_RD, addr_of(4), 3'd4});
            tick();
        end
        for (int k = 0; k < 9; k++) chk($sformatf("lit_dir_seq%0d", k), g[k], exp_dir[k]);
        all_idle();
        repeat (3) tick();

        // Issue FIFO full for ten cycles with three PRE requests pending.
        full = 1'b1;
        set_bank(1, S_PRE);
        set_bank(3, S_PRE);
        set_bank(6, S_PRE);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("lit_full_grant", ba_grant, 0);
            chk("lit_full_issue", sch_issue, 0);
            tick();
        end
        full = 1'b0;
        @(negedge clk);
        chk("lit_resume_1", ba_grant, 8'h02);
        tick();
        set_bank(1, S_IDLE);
        @(negedge clk);
        chk("lit_resume_3", ba_grant, 8'h08);
        chk("lit_resume_out", sch_out, {K_PRE, addr_of(1), 3'd1});
        tick();
        set_bank(3, S_IDLE);
        @(negedge clk);
        chk("lit_resume_6", ba_grant, 8'h40);
        tick();
        set_bank(6, S_IDLE);
        repeat (2) tick();

        // Reset arriving with an issue pending.
        set_bank(0, S_ACT);
        @(negedge clk);
        chk("lit_pre_rst_grant", ba_grant, 8'h01);
        tick();
        chk("lit_pre_rst_issue", sch_issue, 1);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_drop_issue", sch_issue, 0);
        chk("lit_rst_drop_out", sch_out, 0);
        chk("lit_rst_drop_stall", ba_stall, 32'hFF);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_grant", ba_grant, 8'h01);
        tick();
        all_idle();

        // Mixed traffic checked by the model alone.
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < NB; i++) set_bank(i, 4'($urandom_range(0, 9)));
            full = ($urandom_range(0, 7) == 0);
            tick();
        end
        all_idle();
        full = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
